// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and defaults for the BCD countdown timer
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef logic [3:0] bcd_t;

  localparam int LO_MAX_DEF = 9;
  localparam int HI_MAX_DEF = 9;

  function automatic bcd_t bcd_sat(input bcd_t v, input bcd_t max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit with saturating load and wrap-to-MAX borrow
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  output bcd_t value,
  output logic borrow
);

  localparam bcd_t MAX_B = bcd_t'(MAX);

  // Borrow is only meaningful when the decrement actually wins this cycle.
  assign borrow = dec && !clr && !load && (value == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 4'd0;
    end else if (clr) begin
      value <= 4'd0;
    end else if (load) begin
      value <= bcd_sat(load_val, MAX_B);
    end else if (dec) begin
      value <= (value == 4'd0) ? MAX_B : value - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - two-digit BCD countdown timer with run/pause/done control
// Optional: define AUTO_RELOAD_EN to reload the captured start value on the terminal tick.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int LO_MAX = LO_MAX_DEF,
  parameter int HI_MAX = HI_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [3:0] load_lo,
  input  logic [3:0] load_hi,
  output logic [3:0] cnt_lo,
  output logic [3:0] cnt_hi,
  output logic       running,
  output logic       borrow,
  output logic       done,
  output logic       set_reset
);

  localparam bcd_t LO_MAX_B = bcd_t'(LO_MAX);
  localparam bcd_t HI_MAX_B = bcd_t'(HI_MAX);

  state_t state;
  logic   start_ok, pause_ok, dec_lo, dec_hi, terminal, load_zero;
  logic   lo_borrow, hi_borrow_unused;
  logic   digit_load;
  bcd_t   digit_lo_val, digit_hi_val;

  // start is ignored in RUN, so it does not block pause or tick there.
  assign start_ok  = start && !clear && (state != RUN);
  assign pause_ok  = pause && !clear && !start_ok && (state == RUN || state == PAUSE);
  assign dec_lo    = tick && !clear && !start_ok && !pause && (state == RUN);
  assign dec_hi    = dec_lo && lo_borrow;
  assign terminal  = dec_lo && (cnt_lo == 4'd1) && (cnt_hi == 4'd0);
  assign load_zero = (bcd_sat(load_lo, LO_MAX_B) == 4'd0) && (bcd_sat(load_hi, HI_MAX_B) == 4'd0);

`ifdef AUTO_RELOAD_EN
  bcd_t reload_lo, reload_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_lo <= 4'd0;
      reload_hi <= 4'd0;
    end else if (start_ok) begin
      reload_lo <= bcd_sat(load_lo, LO_MAX_B);
      reload_hi <= bcd_sat(load_hi, HI_MAX_B);
    end
  end

  assign digit_load   = start_ok || terminal;
  assign digit_lo_val = start_ok ? load_lo : reload_lo;
  assign digit_hi_val = start_ok ? load_hi : reload_hi;
`else
  assign digit_load   = start_ok;
  assign digit_lo_val = load_lo;
  assign digit_hi_val = load_hi;
`endif

  bcd_down_digit #(.MAX(LO_MAX)) u_lo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear),
    .load     (digit_load),
    .load_val (digit_lo_val),
    .dec      (dec_lo),
    .value    (cnt_lo),
    .borrow   (lo_borrow)
  );

  bcd_down_digit #(.MAX(HI_MAX)) u_hi (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear),
    .load     (digit_load),
    .load_val (digit_hi_val),
    .dec      (dec_hi),
    .value    (cnt_hi),
    .borrow   (hi_borrow_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      borrow    <= 1'b0;
      set_reset <= 1'b0;
    end else begin
      borrow    <= 1'b0;
      set_reset <= 1'b0;
      if (clear) begin
        state <= IDLE;
      end else if (start_ok) begin
        if (load_zero) begin
          state     <= DONE;
          set_reset <= 1'b1;
        end else begin
          state <= RUN;
        end
      end else if (pause_ok) begin
        state <= (state == RUN) ? PAUSE : RUN;
      end else if (dec_lo) begin
        borrow <= lo_borrow;
        if (terminal) begin
          set_reset <= 1'b1;
`ifndef AUTO_RELOAD_EN
          state <= DONE;
`endif
        end
      end
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [3:0] load_lo = 4'd0, load_hi = 4'd0;
  logic [3:0] cnt_lo, cnt_hi;
  logic       running, borrow, done, set_reset;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_countdown_timer dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .load_lo   (load_lo),
    .load_hi   (load_hi),
    .cnt_lo    (cnt_lo),
    .cnt_hi    (cnt_hi),
    .running   (running),
    .borrow    (borrow),
    .done      (done),
    .set_reset (set_reset)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [3:0] hi, input logic [3:0] lo);
    load_hi = hi; load_lo = lo; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    n_checks++;
    if ({cnt_hi, cnt_lo, running, borrow, done, set_reset} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset: got cnt=%h%h run=%b bor=%b done=%b sr=%b want all 0",
               cnt_hi, cnt_lo, running, borrow, done, set_reset);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_countdown();
    logic [7:0] exp;
    do_start(4'd1, 4'd2);
    n_checks++;
    if ({cnt_hi, cnt_lo} !== 8'h12 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL cd_load: got cnt=%h%h run=%b want 12 run=1", cnt_hi, cnt_lo, running);
    end
    for (int i = 1; i <= 12; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      exp = 8'(((12 - i) / 10) * 16 + ((12 - i) % 10));
      n_checks++;
      if ({cnt_hi, cnt_lo} !== exp || borrow !== (i == 3) || set_reset !== (i == 12) ||
          done !== (i == 12) || running !== (i < 12)) begin
        n_fail++;
        $display("FAIL cd_tick%0d: got cnt=%h%h bor=%b sr=%b done=%b run=%b want cnt=%h bor=%b sr=%b done=%b run=%b",
                 i, cnt_hi, cnt_lo, borrow, set_reset, done, running, exp,
                 (i == 3), (i == 12), (i == 12), (i < 12));
      end
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if ({cnt_hi, cnt_lo} !== 8'h00 || done !== 1'b1 || set_reset !== 1'b0 || borrow !== 1'b0) begin
      n_fail++;
      $display("FAIL cd_hold: got cnt=%h%h done=%b sr=%b bor=%b want 00 done=1 sr=0 bor=0",
               cnt_hi, cnt_lo, done, set_reset, borrow);
    end
    do_clear();
  endtask

  task automatic test_zero_load();
    do_start(4'd0, 4'd0);
    n_checks++;
    if ({cnt_hi, cnt_lo} !== 8'h00 || done !== 1'b1 || set_reset !== 1'b1 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_load: got cnt=%h%h done=%b sr=%b run=%b want 00 done=1 sr=1 run=0",
               cnt_hi, cnt_lo, done, set_reset, running);
    end
    step();
    n_checks++;
    if (done !== 1'b1 || set_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_after: got done=%b sr=%b want done=1 sr=0", done, set_reset);
    end
    do_clear();
  endtask

  task automatic test_pause();
    logic [7:0] exp_tab [0:2];
    exp_tab[0] = 8'h52; exp_tab[1] = 8'h51; exp_tab[2] = 8'h50;
    do_start(4'd5, 4'd3);
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      n_checks++;
      if ({cnt_hi, cnt_lo} !== exp_tab[i]) begin
        n_fail++;
        $display("FAIL pause_pre%0d: got cnt=%h%h want %h", i, cnt_hi, cnt_lo, exp_tab[i]);
      end
    end
    pause = 1'b1; step(); pause = 1'b0;
    n_checks++;
    if (running !== 1'b0 || {cnt_hi, cnt_lo} !== 8'h51) begin
      n_fail++;
      $display("FAIL pause_enter: got run=%b cnt=%h%h want run=0 cnt=51", running, cnt_hi, cnt_lo);
    end
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      n_checks++;
      if ({cnt_hi, cnt_lo} !== 8'h51 || running !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold%0d: got cnt=%h%h run=%b want 51 run=0", i, cnt_hi, cnt_lo, running);
      end
    end
    pause = 1'b1; step(); pause = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    n_checks++;
    if ({cnt_hi, cnt_lo} !== exp_tab[2] || running !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_resume: got cnt=%h%h run=%b want 50 run=1", cnt_hi, cnt_lo, running);
    end
    do_clear();
  endtask

  task automatic test_saturate_reset();
    do_start(4'hF, 4'hC);
    n_checks++;
    if ({cnt_hi, cnt_lo} !== 8'h99) begin
      n_fail++;
      $display("FAIL sat_load: got cnt=%h%h want 99", cnt_hi, cnt_lo);
    end
    for (int i = 0; i < 52; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
    n_checks++;
    if ({cnt_hi, cnt_lo} !== 8'h47 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_count: got cnt=%h%h run=%b want 47 run=1", cnt_hi, cnt_lo, running);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({cnt_hi, cnt_lo} !== 8'h00 || running !== 1'b0 || done !== 1'b0 || set_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got cnt=%h%h run=%b done=%b sr=%b want 00 0 0 0",
               cnt_hi, cnt_lo, running, done, set_reset);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_priority();
    do_start(4'd0, 4'd3);
    clear = 1'b1; start = 1'b1; load_hi = 4'd5; load_lo = 4'd5;
    step();
    clear = 1'b0; start = 1'b0;
    n_checks++;
    if ({cnt_hi, cnt_lo} !== 8'h00 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_start: got cnt=%h%h run=%b done=%b want 00 0 0", cnt_hi, cnt_lo, running, done);
    end
    do_start(4'd0, 4'd4);
    tick = 1'b1; step(); tick = 1'b0;
    n_checks++;
    if ({cnt_hi, cnt_lo} !== 8'h03) begin
      n_fail++;
      $display("FAIL prio_tick: got cnt=%h%h want 03", cnt_hi, cnt_lo);
    end
    pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
    n_checks++;
    if ({cnt_hi, cnt_lo} !== 8'h03 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_tick: got cnt=%h%h run=%b want 03 run=0", cnt_hi, cnt_lo, running);
    end
    do_clear();
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [7:0] exp_tab [0:3];
    exp_tab[0] = 8'h01; exp_tab[1] = 8'h02; exp_tab[2] = 8'h01; exp_tab[3] = 8'h02;
    do_start(4'd0, 4'd2);
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      n_checks++;
      if ({cnt_hi, cnt_lo} !== exp_tab[i] || set_reset !== (i == 1 || i == 3) ||
          running !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reload%0d: got cnt=%h%h sr=%b run=%b done=%b want %h sr=%b run=1 done=0",
                 i, cnt_hi, cnt_lo, set_reset, running, done, exp_tab[i], (i == 1 || i == 3));
      end
    end
    do_clear();
  endtask
`endif

  initial begin
    test_reset();
`ifdef AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_countdown();
`endif
    test_zero_load();
    test_pause();
    test_saturate_reset();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
